// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the fixed<->float converters.
package fp_pkg;

    localparam int FP_EXP_BIAS = 127;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MANT_W   = 23;

    // Normalisation runs shift steps of 16, 8, 4, 2, 1.
    localparam int NORM_STEPS  = 5;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp32_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABS,
        ST_NORM,
        ST_PACK,
        ST_OUT
    } state_t;

endpackage

// File: rtl/fp_round_pack.sv
// Rounding, exponent carry and field packing for a normalised magnitude.
// Build option: FIXED_TO_FP_RNE_EN selects round-to-nearest-even;
// without it the mantissa is truncated and no carry logic exists.
module fp_round_pack
    import fp_pkg::*;
(
    input  logic        i_sign,
    input  logic        i_zero,
    input  logic [7:0]  i_exp,
    input  logic [31:0] i_mag,
    output logic [31:0] o_fp
);

    logic [FP_MANT_W-1:0] w_mant;
    logic [FP_MANT_W-1:0] w_mant_out;
    logic [FP_EXP_W-1:0]  w_exp_out;
    logic                 w_unused;
    fp32_t                w_fp;

    // Bit 31 is the implicit leading one and is dropped.
    assign w_mant = i_mag[30:8];

`ifdef FIXED_TO_FP_RNE_EN
    logic w_guard;
    logic w_sticky;
    logic w_round_up;
    logic w_carry;

    assign w_guard    = i_mag[7];
    assign w_sticky   = |i_mag[6:0];
    assign w_round_up = w_guard && (w_sticky || w_mant[0]);
    // An all-ones mantissa rounding up wraps to zero and bumps the exponent.
    assign {w_carry, w_mant_out} = {1'b0, w_mant} + 24'(w_round_up);
    assign w_exp_out  = i_exp + 8'(w_carry);
    assign w_unused   = i_mag[31];
`else
    assign w_mant_out = w_mant;
    assign w_exp_out  = i_exp;
    assign w_unused   = ^{i_mag[31], i_mag[7:0]};
`endif

    // Zero input always packs as +0.0.
    always_comb begin
        w_fp      = '0;
        w_fp.sign = i_sign;
        w_fp.exp  = w_exp_out;
        w_fp.mant = w_mant_out;
        if (i_zero) begin
            w_fp = '0;
        end
    end

    assign o_fp = w_fp;

endmodule

// File: rtl/fixed_to_fp.sv
// Signed fixed-point (FRAC_W fractional bits) to IEEE-754 single converter.
// Fixed 7-cycle latency: ABS, five normalisation steps, PACK.
// Rounding mode chosen inside fp_round_pack via FIXED_TO_FP_RNE_EN.
module fixed_to_fp
    import fp_pkg::*;
#(
    parameter int FRAC_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] fixed_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [31:0] fp_o,
    output logic        out_valid_o,
    input  logic        out_ready_i
);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_x;
    logic        r_sign;
    logic        r_zero;
    logic [31:0] r_mag;
    logic [4:0]  r_lz;
    logic [2:0]  r_step;
    logic [31:0] r_fp;

    logic [4:0]  w_k;
    logic [31:0] w_hi_mask;
    logic [8:0]  w_exp9;
    logic [31:0] w_fp;
    logic        w_unused;

    // Step k halves each NORM cycle; the mask selects mag[31:32-k].
    assign w_k       = 5'd16 >> r_step;
    assign w_hi_mask = ~(32'hFFFF_FFFF >> w_k);

    // Exponent stays in 96..158, so the top bit of the 9-bit result is never set.
    assign w_exp9    = 9'(FP_EXP_BIAS + 31) - {4'b0, r_lz} - 9'(FRAC_W);
    assign w_unused  = w_exp9[8];

    fp_round_pack u_round_pack (
        .i_sign (r_sign),
        .i_zero (r_zero),
        .i_exp  (w_exp9[7:0]),
        .i_mag  (r_mag),
        .o_fp   (w_fp)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    w_next_state = ST_ABS;
                end
            end
            ST_ABS:  w_next_state = ST_NORM;
            ST_NORM: begin
                if (r_step == 3'(NORM_STEPS - 1)) begin
                    w_next_state = ST_PACK;
                end
            end
            ST_PACK: w_next_state = ST_OUT;
            ST_OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: capture, absolute value, leading-zero shift, result register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x    <= '0;
            r_sign <= 1'b0;
            r_zero <= 1'b0;
            r_mag  <= '0;
            r_lz   <= '0;
            r_step <= '0;
            r_fp   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        r_x <= fixed_i;
                    end
                end
                ST_ABS: begin
                    // -2^31 negates to itself, which is the correct unsigned magnitude.
                    r_sign <= r_x[31];
                    r_mag  <= r_x[31] ? (~r_x + 32'd1) : r_x;
                    r_zero <= (r_x == 32'd0);
                    r_lz   <= '0;
                    r_step <= '0;
                end
                ST_NORM: begin
                    if ((r_mag & w_hi_mask) == 32'd0) begin
                        r_mag <= r_mag << w_k;
                        r_lz  <= r_lz + w_k;
                    end
                    r_step <= r_step + 3'd1;
                end
                ST_PACK: r_fp <= w_fp;
                default: ;
            endcase
        end
    end

    assign fp_o = r_fp;

endmodule

// File: tb/tb_fixed_to_fp.sv
// Directed bench for fixed_to_fp with FRAC_W = 16.
module tb_fixed_to_fp;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] fixed_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] fp_o;
    logic        out_valid_o;
    logic        out_ready_i;

    int n_checks = 0;
    int n_fail   = 0;

    fixed_to_fp #(.FRAC_W(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .fixed_i     (fixed_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .fp_o        (fp_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Presents x, waits for acceptance, then counts edges until out_valid.
    // Returns one edge after the output handshake when out_ready_i is high.
    task automatic do_convert(input logic [31:0] x, output logic [31:0] fp, output int lat);
        int n_wait;
        n_wait = 0;
        fixed_i    = x;
        in_valid_i = 1'b1;
        while (!in_ready_o && n_wait < 50) begin
            @(posedge clk_i); #1;
            n_wait++;
        end
        if (!in_ready_o) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout x=%h in_ready=%b required 1", x, in_ready_o);
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        lat = 0;
        while (!out_valid_o && lat < 50) begin
            @(posedge clk_i); #1;
            lat++;
        end
        if (!out_valid_o) begin
            n_checks++; n_fail++;
            $display("FAIL result_timeout x=%h out_valid=%b required 1", x, out_valid_o);
        end
        fp = fp_o;
        if (out_ready_i) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        fixed_i     = 32'h0;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++;
        if (in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b required 1", in_ready_o);
        end
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b required 0", out_valid_o);
        end
        n_checks++;
        if (fp_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_fp got %h required 00000000", fp_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] fp;
        int lat;
        do_convert(32'h0001_0000, fp, lat);
        n_checks++;
        if (fp !== 32'h3F80_0000) begin
            n_fail++; $display("FAIL basic_one got %h required 3f800000", fp);
        end
        n_checks++;
        if (lat !== 7) begin
            n_fail++; $display("FAIL basic_latency got %0d required 7", lat);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] vin  [8];
        logic [31:0] vexp [8];
        logic [31:0] fp;
        int lat;
        vin[0] = 32'hFFFD_8000; vexp[0] = 32'hC020_0000;  // -2.5
        vin[1] = 32'h0000_0000; vexp[1] = 32'h0000_0000;  // zero
        vin[2] = 32'h8000_0000; vexp[2] = 32'hC700_0000;  // -32768.0
        vin[3] = 32'h0000_0001; vexp[3] = 32'h3780_0000;  // 2^-16
        vin[4] = 32'hFFFF_FFFF; vexp[4] = 32'hB780_0000;  // -2^-16
        vin[5] = 32'h0001_8000; vexp[5] = 32'h3FC0_0000;  // 1.5
        vin[6] = 32'h0100_0001; vexp[6] = 32'h4380_0000;  // tie, even stays
`ifdef FIXED_TO_FP_RNE_EN
        vin[7] = 32'h0100_0003; vexp[7] = 32'h4380_0002;  // tie, odd rounds up
`else
        vin[7] = 32'h0100_0003; vexp[7] = 32'h4380_0001;
`endif
        for (int i = 0; i < 8; i++) begin
            do_convert(vin[i], fp, lat);
            n_checks++;
            if (fp !== vexp[i]) begin
                n_fail++; $display("FAIL vector_%0d in=%h got %h required %h", i, vin[i], fp, vexp[i]);
            end
            n_checks++;
            if (lat !== 7) begin
                n_fail++; $display("FAIL vector_%0d_latency got %0d required 7", i, lat);
            end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] fp;
        logic [31:0] req;
        int lat;
`ifdef FIXED_TO_FP_RNE_EN
        req = 32'h4700_0000;
`else
        req = 32'h46FF_FFFF;
`endif
        do_convert(32'h7FFF_FFFF, fp, lat);
        n_checks++;
        if (fp !== req) begin
            n_fail++; $display("FAIL rounding_max got %h required %h", fp, req);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] fp;
        int lat;
        out_ready_i = 1'b0;
        do_convert(32'h0001_8000, fp, lat);
        n_checks++;
        if (fp !== 32'h3FC0_0000) begin
            n_fail++; $display("FAIL bp_result got %h required 3fc00000", fp);
        end
        fixed_i    = 32'h0001_0000;
        in_valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i); #1;
            n_checks++;
            if (fp_o !== 32'h3FC0_0000 || out_valid_o !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold_%0d got fp=%h valid=%b required 3fc00000/1", c, fp_o, out_valid_o);
            end
            n_checks++;
            if (in_ready_o !== 1'b0) begin
                n_fail++; $display("FAIL bp_in_ready_%0d got %b required 0", c, in_ready_o);
            end
        end
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        n_checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_release got ready=%b valid=%b required 1/0", in_ready_o, out_valid_o);
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        n_checks++;
        if (in_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_next_accept got in_ready=%b required 0", in_ready_o);
        end
        lat = 0;
        while (!out_valid_o && lat < 50) begin
            @(posedge clk_i); #1;
            lat++;
        end
        n_checks++;
        if (fp_o !== 32'h3F80_0000 || lat !== 7) begin
            n_fail++; $display("FAIL bp_next_result got %h lat %0d required 3f800000 lat 7", fp_o, lat);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] fp;
        int lat;
        fixed_i    = 32'h0001_0000;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;   // accept
        in_valid_i = 1'b0;
        repeat (3) begin
            @(posedge clk_i); #1;
        end
        rst_i = 1'b1;           // third NORM cycle
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        in_valid_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_state got valid=%b ready=%b required 0/1", out_valid_o, in_ready_o);
        end
        n_checks++;
        if (fp_o !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_fp got %h required 00000000", fp_o);
        end
        do_convert(32'h0001_0000, fp, lat);
        n_checks++;
        if (fp !== 32'h3F80_0000 || lat !== 7) begin
            n_fail++; $display("FAIL rst_mid_after got %h lat %0d required 3f800000 lat 7", fp, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_rounding();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
